// File: rtl/pong_pkg.sv
// Shared geometry, timing constants and state encoding for the Pong game controller.
// Coordinates are widened to 13 bits for every comparison so no sum or difference can wrap.
package pong_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int BAR_LEN      = 180;
    localparam int BAR_W        = 20;
    localparam int BALL_SIZE    = 20;
    localparam int BAR_SPEED    = 4;
    localparam int BALL_SPEED   = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    localparam int BALL_X0   = (H_RES - BALL_SIZE) / 2;
    localparam int BALL_Y0   = (V_RES - BALL_SIZE) / 2;
    localparam int BAR_Y0    = (V_RES - BAR_LEN) / 2;
    localparam int BAR_Y_MAX = V_RES - BAR_LEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef logic [12:0] coord_t;

    // True when the ball's vertical extent intersects the paddle's vertical extent.
    function automatic logic overlap(input coord_t ball_y, input coord_t bar_y);
        return ((ball_y + coord_t'(BALL_SIZE)) > bar_y) &&
               (ball_y < (bar_y + coord_t'(BAR_LEN)));
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: vertical position stepped up or down once per enabled frame,
// saturating at the top and bottom of the screen.
module pong_paddle
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up,
    input  logic        down,
    output logic [11:0] y
);

    logic [11:0] y_reg;
    logic [11:0] y_next;
    coord_t      y_ext;

    assign y_ext = {1'b0, y_reg};
    assign y     = y_reg;

    // Pressing both buttons cancels out, same as pressing neither.
    always_comb begin
        y_next = y_reg;
        if (en && up && !down) begin
            if (y_ext < coord_t'(BAR_SPEED)) begin
                y_next = '0;
            end else begin
                y_next = 12'(y_ext - coord_t'(BAR_SPEED));
            end
        end else if (en && down && !up) begin
            if ((y_ext + coord_t'(BAR_SPEED)) > coord_t'(BAR_Y_MAX)) begin
                y_next = 12'(BAR_Y_MAX);
            end else begin
                y_next = 12'(y_ext + coord_t'(BAR_SPEED));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= 12'(BAR_Y0);
        end else begin
            y_reg <= y_next;
        end
    end

endmodule

// File: rtl/pong_ctrl.sv
// Frame-synchronous Pong controller: paddles, ball motion, bounces, scoring and
// the idle/serve/play/over sequencing, all updated once per video frame.
module pong_ctrl
    import pong_pkg::*;
(
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_animate,
    input  logic        in_start,
    input  logic        in_left_up,
    input  logic        in_left_down,
    input  logic        in_right_up,
    input  logic        in_right_down,
    output logic [11:0] out_ball_x,
    output logic [11:0] out_ball_y,
    output logic [11:0] out_left_y,
    output logic [11:0] out_right_y,
    output logic [3:0]  out_score_l,
    output logic [3:0]  out_score_r,
    output logic [1:0]  out_state
);

    localparam coord_t LEFT_CONTACT  = coord_t'(BAR_W + BALL_SPEED);
    localparam coord_t RIGHT_CONTACT = coord_t'(H_RES - BAR_W);
    localparam coord_t RIGHT_LIMIT   = coord_t'(H_RES);
    localparam coord_t BOTTOM_LIMIT  = coord_t'(V_RES);
    localparam coord_t STEP          = coord_t'(BALL_SPEED);
    localparam coord_t SIZE          = coord_t'(BALL_SIZE);

    state_t      state_reg, state_next;
    logic [11:0] ball_x_reg, ball_x_next;
    logic [11:0] ball_y_reg, ball_y_next;
    logic        dir_right_reg, dir_right_next;
    logic        dir_down_reg, dir_down_next;
    logic [3:0]  score_l_reg, score_l_next;
    logic [3:0]  score_r_reg, score_r_next;
    logic [7:0]  serve_cnt_reg, serve_cnt_next;
    logic        animate_q, start_q;

    logic        tick, start_edge, paddle_en;
    logic [1:0]  paddle_up, paddle_down;
    logic [11:0] paddle_y [2];

    coord_t      bx, by, ly, ry;
    logic [11:0] x_play, y_play;
    logic        right_play, down_play;
    logic        point_l, point_r;
    logic [3:0]  score_l_inc, score_r_inc;

    assign tick       = in_animate & ~animate_q;
    assign start_edge = in_start & ~start_q;
    assign paddle_en  = tick && ((state_reg == ST_SERVE) || (state_reg == ST_PLAY));

    assign paddle_up   = {in_right_up,   in_left_up};
    assign paddle_down = {in_right_down, in_left_down};

    // Index 0 is the left paddle, index 1 the right paddle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_paddle
            pong_paddle u_paddle (
                .clk   (in_clock),
                .rst_n (in_reset),
                .en    (paddle_en),
                .up    (paddle_up[gi]),
                .down  (paddle_down[gi]),
                .y     (paddle_y[gi])
            );
        end
    endgenerate

    assign bx = {1'b0, ball_x_reg};
    assign by = {1'b0, ball_y_reg};
    assign ly = {1'b0, paddle_y[0]};
    assign ry = {1'b0, paddle_y[1]};

    // Candidate ball motion for a play tick; both axes use pre-update positions.
    always_comb begin
        y_play     = ball_y_reg;
        down_play  = dir_down_reg;
        x_play     = ball_x_reg;
        right_play = dir_right_reg;
        point_l    = 1'b0;
        point_r    = 1'b0;

        if (!dir_down_reg) begin
            if (by < STEP) begin
                y_play    = '0;
                down_play = 1'b1;
            end else begin
                y_play = 12'(by - STEP);
            end
        end else begin
            if ((by + SIZE + STEP) > BOTTOM_LIMIT) begin
                y_play    = 12'(V_RES - BALL_SIZE);
                down_play = 1'b0;
            end else begin
                y_play = 12'(by + STEP);
            end
        end

        if (!dir_right_reg) begin
            if ((bx < LEFT_CONTACT) && overlap(by, ly)) begin
                x_play     = 12'(BAR_W);
                right_play = 1'b1;
            end else if ((bx < LEFT_CONTACT) && (bx < STEP)) begin
                point_r = 1'b1;
            end else begin
                x_play = 12'(bx - STEP);
            end
        end else begin
            if (((bx + SIZE + STEP) > RIGHT_CONTACT) && overlap(by, ry)) begin
                x_play     = 12'(H_RES - BAR_W - BALL_SIZE);
                right_play = 1'b0;
            end else if ((bx + SIZE + STEP) > RIGHT_LIMIT) begin
                point_l = 1'b1;
            end else begin
                x_play = 12'(bx + STEP);
            end
        end
    end

    assign score_l_inc = score_l_reg + 4'd1;
    assign score_r_inc = score_r_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        ball_x_next    = ball_x_reg;
        ball_y_next    = ball_y_reg;
        dir_right_next = dir_right_reg;
        dir_down_next  = dir_down_reg;
        score_l_next   = score_l_reg;
        score_r_next   = score_r_reg;
        serve_cnt_next = serve_cnt_reg;

        unique case (state_reg)
            ST_IDLE: begin
                ball_x_next = 12'(BALL_X0);
                ball_y_next = 12'(BALL_Y0);
                if (start_edge) begin
                    state_next     = ST_SERVE;
                    serve_cnt_next = 8'(SERVE_FRAMES);
                end
            end
            ST_SERVE: begin
                ball_x_next = 12'(BALL_X0);
                ball_y_next = 12'(BALL_Y0);
                if (tick) begin
                    serve_cnt_next = serve_cnt_reg - 8'd1;
                    if (serve_cnt_reg == 8'd1) begin
                        state_next = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (point_l) begin
                        score_l_next = score_l_inc;
                        if (score_l_inc == 4'(WIN_SCORE)) begin
                            state_next = ST_OVER;
                        end else begin
                            state_next     = ST_SERVE;
                            serve_cnt_next = 8'(SERVE_FRAMES);
                            ball_x_next    = 12'(BALL_X0);
                            ball_y_next    = 12'(BALL_Y0);
                            dir_right_next = 1'b1;
                        end
                    end else if (point_r) begin
                        score_r_next = score_r_inc;
                        if (score_r_inc == 4'(WIN_SCORE)) begin
                            state_next = ST_OVER;
                        end else begin
                            state_next     = ST_SERVE;
                            serve_cnt_next = 8'(SERVE_FRAMES);
                            ball_x_next    = 12'(BALL_X0);
                            ball_y_next    = 12'(BALL_Y0);
                            dir_right_next = 1'b0;
                        end
                    end else begin
                        ball_x_next    = x_play;
                        ball_y_next    = y_play;
                        dir_right_next = right_play;
                        dir_down_next  = down_play;
                    end
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_next     = ST_SERVE;
                    serve_cnt_next = 8'(SERVE_FRAMES);
                    score_l_next   = '0;
                    score_r_next   = '0;
                    ball_x_next    = 12'(BALL_X0);
                    ball_y_next    = 12'(BALL_Y0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_reg     <= ST_IDLE;
            ball_x_reg    <= 12'(BALL_X0);
            ball_y_reg    <= 12'(BALL_Y0);
            dir_right_reg <= 1'b1;
            dir_down_reg  <= 1'b1;
            score_l_reg   <= '0;
            score_r_reg   <= '0;
            serve_cnt_reg <= '0;
            animate_q     <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ball_x_reg    <= ball_x_next;
            ball_y_reg    <= ball_y_next;
            dir_right_reg <= dir_right_next;
            dir_down_reg  <= dir_down_next;
            score_l_reg   <= score_l_next;
            score_r_reg   <= score_r_next;
            serve_cnt_reg <= serve_cnt_next;
            animate_q     <= in_animate;
            start_q       <= in_start;
        end
    end

    assign out_ball_x  = ball_x_reg;
    assign out_ball_y  = ball_y_reg;
    assign out_left_y  = paddle_y[0];
    assign out_right_y = paddle_y[1];
    assign out_score_l = score_l_reg;
    assign out_score_r = score_r_reg;
    assign out_state   = state_reg;

endmodule

// File: tb/tb_pong_ctrl.sv
// Bench for pong_ctrl: a frame-level game model predicts every output each clock,
// and directed constant checks cover reset, serve timing, saturation and game over.
module tb_pong_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        animate = 1'b0;
    logic        start = 1'b0;
    logic        lu = 1'b0, ld = 1'b0, ru = 1'b0, rd = 1'b0;
    logic [11:0] ball_x, ball_y, left_y, right_y;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;

    pong_ctrl dut (
        .in_clock      (clk),
        .in_reset      (rst_n),
        .in_animate    (animate),
        .in_start      (start),
        .in_left_up    (lu),
        .in_left_down  (ld),
        .in_right_up   (ru),
        .in_right_down (rd),
        .out_ball_x    (ball_x),
        .out_ball_y    (ball_y),
        .out_left_y    (left_y),
        .out_right_y   (right_y),
        .out_score_l   (score_l),
        .out_score_r   (score_r),
        .out_state     (state)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_bx, m_by, m_ly, m_ry, m_sl, m_sr, m_st, m_cnt;
    bit m_dr, m_dd, m_aq, m_sq;
    logic [57:0] exp_q [$];

    task automatic model_reset();
        m_bx = 310; m_by = 230; m_ly = 150; m_ry = 150;
        m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
        m_dr = 1'b1; m_dd = 1'b1; m_aq = 1'b0; m_sq = 1'b0;
    endtask

    function automatic int pad_next(input int y, input bit u, input bit d);
        if (u && !d) return (y < 4) ? 0 : y - 4;
        if (d && !u) return (y + 4 > 300) ? 300 : y + 4;
        return y;
    endfunction

    function automatic bit hits(input int by, input int pad);
        return (by + 20 > pad) && (by < pad + 180);
    endfunction

    task automatic model_serve(input bit toward_right);
        m_st = 1; m_cnt = 60; m_bx = 310; m_by = 230; m_dr = toward_right;
    endtask

    task automatic model_play(input int ly0, input int ry0);
        int nx, ny;
        bit ndr, ndd, pt_l, pt_r;
        nx = m_bx; ndr = m_dr; pt_l = 1'b0; pt_r = 1'b0;
        if (!m_dd) begin
            ndd = (m_by < 2);
            ny  = (m_by < 2) ? 0 : m_by - 2;
        end else if (m_by + 22 > 480) begin
            ny = 460; ndd = 1'b0;
        end else begin
            ny = m_by + 2; ndd = 1'b1;
        end
        if (!m_dr) begin
            if (m_bx < 22 && hits(m_by, ly0)) begin nx = 20; ndr = 1'b1; end
            else if (m_bx < 2) pt_r = 1'b1;
            else nx = m_bx - 2;
        end else begin
            if (m_bx + 22 > 620 && hits(m_by, ry0)) begin nx = 600; ndr = 1'b0; end
            else if (m_bx + 22 > 640) pt_l = 1'b1;
            else nx = m_bx + 2;
        end
        if (pt_l) begin
            m_sl++;
            if (m_sl == 9) m_st = 3; else model_serve(1'b1);
        end else if (pt_r) begin
            m_sr++;
            if (m_sr == 9) m_st = 3; else model_serve(1'b0);
        end else begin
            m_bx = nx; m_by = ny; m_dr = ndr; m_dd = ndd;
        end
    endtask

    task automatic model_step(input bit a, input bit s, input bit l_up, input bit l_dn,
                              input bit r_up, input bit r_dn);
        bit tk, se;
        int ly0, ry0;
        tk = a && !m_aq;
        se = s && !m_sq;
        m_aq = a; m_sq = s;
        ly0 = m_ly; ry0 = m_ry;
        if (tk && (m_st == 1 || m_st == 2)) begin
            m_ly = pad_next(m_ly, l_up, l_dn);
            m_ry = pad_next(m_ry, r_up, r_dn);
        end
        case (m_st)
            0: if (se) begin m_st = 1; m_cnt = 60; end
            1: if (tk) begin m_cnt--; if (m_cnt == 0) m_st = 2; end
            2: if (tk) model_play(ly0, ry0);
            3: if (se) begin m_sl = 0; m_sr = 0; model_serve(m_dr); end
            default: ;
        endcase
    endtask

    function automatic logic [57:0] model_vec();
        return {12'(m_bx), 12'(m_by), 12'(m_ly), 12'(m_ry), 4'(m_sl), 4'(m_sr), 2'(m_st)};
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input bit a, input bit s, input bit l_up, input bit l_dn,
                        input bit r_up, input bit r_dn);
        logic [57:0] exp_v;
        animate = a; start = s; lu = l_up; ld = l_dn; ru = r_up; rd = r_dn;
        model_step(a, s, l_up, l_dn, r_up, r_dn);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check_val("outputs", {ball_x, ball_y, left_y, right_y, score_l, score_r, state}, exp_v);
    endtask

    task automatic frame(input bit l_up, input bit l_dn, input bit r_up, input bit r_dn,
                         input int hold);
        for (int i = 0; i < hold; i++) step(1'b1, 1'b0, l_up, l_dn, r_up, r_dn);
        step(1'b0, 1'b0, l_up, l_dn, r_up, r_dn);
        frame_no++;
        $display("frame %0d st=%0d ball=(%0d,%0d) pad=%0d/%0d score=%0d:%0d",
                 frame_no, state, ball_x, ball_y, left_y, right_y, score_l, score_r);
    endtask

    task automatic start_pulse(input bit with_tick, input bit l_dn);
        step(with_tick, 1'b1, 1'b0, l_dn, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("start pulse tick=%0d st=%0d score=%0d:%0d", with_tick, state, score_l, score_r);
    endtask

    // Paddle follows the ball centre using model positions.
    function automatic bit trk_up(input int pad);
        return (m_by + 10) - (pad + 90) < -2;
    endfunction
    function automatic bit trk_dn(input int pad);
        return (m_by + 10) - (pad + 90) > 2;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ball_x", ball_x, 310);
        check_val("rst_ball_y", ball_y, 230);
        check_val("rst_left_y", left_y, 150);
        check_val("rst_right_y", right_y, 150);
        check_val("rst_scores", {score_l, score_r}, 0);
        check_val("rst_state", state, 0);
        rst_n = 1'b1;

        frame(1'b0, 1'b0, 1'b0, 1'b0, 3);
        check_val("idle_hold", state, 0);

        start_pulse(1'b0, 1'b0);
        check_val("serve_entry", state, 1);

        for (int t = 1; t <= 60; t++) begin
            frame(t <= 40, 1'b0, 1'b1, 1'b1, 3);
            if (t == 1)  check_val("left_tick1", left_y, 146);
            if (t == 37) check_val("left_tick37", left_y, 2);
            if (t == 38) check_val("left_tick38", left_y, 0);
            if (t == 40) check_val("left_sat", left_y, 0);
            if (t == 59) check_val("serve_t59", state, 1);
            if (t == 60) check_val("serve_t60", state, 2);
            if (t == 60) check_val("both_btn", right_y, 150);
        end
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_val("first_move_x", ball_x, 312);
        check_val("first_move_y", ball_y, 232);

        // Rally with both paddles tracking; a start press mid-play must be ignored.
        for (int f = 0; f < 600; f++) begin
            frame(trk_up(m_ly), trk_dn(m_ly), trk_up(m_ry), trk_dn(m_ry), 1);
            if (f == 150) start_pulse(1'b0, 1'b0);
        end

        // Right paddle dodges the ball so the left player wins.
        for (int f = 0; f < 4000 && m_st != 3; f++) begin
            frame(trk_up(m_ly), trk_dn(m_ly), m_by >= 240, m_by < 240, 1);
        end
        check_val("over_state", state, 3);
        check_val("over_score_l", score_l, 9);

        for (int f = 0; f < 10; f++) begin
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end
        check_val("over_frozen", state, 3);

        start_pulse(1'b1, 1'b1);
        check_val("restart_state", state, 1);
        check_val("restart_scores", {score_l, score_r}, 0);
        check_val("restart_ball", {ball_x, ball_y}, {12'd310, 12'd230});

        for (int f = 0; f < 5; f++) frame(1'b0, 1'b1, 1'b1, 1'b0, 1);
        rst_n = 1'b0;
        #2;
        check_val("async_rst_state", state, 0);
        check_val("async_rst_pads", {left_y, right_y}, {12'd150, 12'd150});
        check_val("async_rst_ball", {ball_x, ball_y}, {12'd310, 12'd230});
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(1'b1, 1'b0, 1'b0, 1'b0, 2);
        check_val("post_rst_idle", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_ctrl.md
# pong_ctrl

Frame-synchronous game controller for the VGA Pong display. Once per video frame it moves both paddles from player buttons, moves the ball, and resolves wall bounces, paddle hits, misses and scoring. It sequences the game through idle, serve, play and game-over phases. It feeds registered object coordinates to the pixel-compare and draw logic in the top level, replacing free-running per-object animators.

## Interface
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- BAR_LEN, 180, paddle height (px)
- BAR_W, 20, paddle width (px); left paddle occupies x in [0,BAR_W), right paddle occupies x in [H_RES-BAR_W,H_RES)
- BALL_SIZE, 20, ball side (px)
- BAR_SPEED, 4, paddle step per frame (px)
- BALL_SPEED, 2, ball step per axis per frame (px)
- SERVE_FRAMES, 60, frames held in SERVE
- WIN_SCORE, 9, points that end the game (≤15)

Ports:
- in_clock  in  1  system clock (50 MHz)
- in_reset  in  1  asynchronous, active-low reset
- in_animate  in  1  end-of-frame level from vga640x480; may stay high for several clocks
- in_start  in  1  start button, synchronous level
- in_left_up, in_left_down, in_right_up, in_right_down  in  1 each  paddle buttons, synchronous levels
- out_ball_x, out_ball_y  out  12  ball top-left corner
- out_left_y, out_right_y  out  12  paddle top edges
- out_score_l, out_score_r  out  4  scores
- out_state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3

## Operation
- tick = in_animate & ~animate_q, giving exactly one update per frame. start_edge = in_start & ~start_q.
- Reset values: ball (310,230), i.e. ((H_RES-BALL_SIZE)/2, (V_RES-BALL_SIZE)/2); paddles 150; scores 0; state IDLE; ball direction right/down; serve counter 0; edge registers 0.
- Paddles, on every tick in SERVE and PLAY:
  - up only: y -= BAR_SPEED, saturating at 0.
  - down only: y += BAR_SPEED, saturating at V_RES-BAR_LEN (300).
  - both or none: hold.
- IDLE: all objects at reset positions. start_edge → SERVE with counter = SERVE_FRAMES.
- SERVE: ball held at centre. Each tick decrements the counter. The tick on which the counter reaches 0 moves to PLAY; the ball does not move on that tick.
- PLAY, per tick, X and Y resolved independently from the current position:
  - Y wall: moving up and y < BALL_SPEED → y=0, direction down. Moving down and y+BALL_SIZE+BALL_SPEED > V_RES → y=V_RES-BALL_SIZE, direction up. Otherwise y ± BALL_SPEED.
  - Overlap test for the paddle on the ball's side: ball_y+BALL_SIZE > bar_y and ball_y < bar_y+BAR_LEN, using pre-update positions.
  - Left side: moving left and x < BAR_W+BALL_SPEED.
    - Overlap → x=BAR_W, direction right.
    - No overlap and x < BALL_SPEED → point to the right player.
    - Otherwise x -= BALL_SPEED.
  - Right side: mirror of left, with contact at x+BALL_SIZE+BALL_SPEED > H_RES-BAR_W. Overlap → x=H_RES-BAR_W-BALL_SIZE (600). Miss when x+BALL_SIZE+BALL_SPEED > H_RES.
  - On a point: the scorer's score increments. If the new score equals WIN_SCORE → OVER. Otherwise → SERVE: ball recentred, counter reloaded, X direction toward the player who conceded, Y direction unchanged.
- OVER: all outputs frozen. start_edge → SERVE with scores cleared and ball centred. Paddles keep their positions.
- start_edge in SERVE or PLAY is ignored.
- Arithmetic: all comparisons use 13-bit unsigned intermediates. No signed values are used, and no wrap-around is possible.

## Timing
- All outputs are registered. Updates land on the clock edge where tick=1, so they are visible one in_clock after the rising edge of in_animate.
- start_edge and tick in the same cycle while in IDLE or OVER: apply the transition. Paddles do not move on that cycle because the state is not yet SERVE.
- Asserting reset at any time immediately forces all reset values. The first tick after release is detected only on a fresh rising edge of in_animate.
- Scores never exceed WIN_SCORE.

## Structure
- pong_pkg holds the state encoding constants and the default geometry constants: H_RES, V_RES, BAR_LEN, BAR_W, BALL_SIZE, and centre positions.
- Sub-module pong_paddle is instantiated twice. It holds paddle y and implements the up/down/saturate logic, with an enable input driven by tick and state. The ball, scoring and FSM logic stay in pong_ctrl.

## Test plan
- Reset release: outputs 310/230/150/150, scores 0/0, state 0. Hold in_animate high for 3 clocks: exactly one tick occurs.
- start pulse, then 60 ticks: state 1 through the 59th tick, 2 after the 60th. The next tick gives ball_x = 312 and ball_y = 232.
- Hold in_left_up in SERVE: left_y steps 146, 142, … and reaches 0 on tick 38, then stays 0. Pressing both buttons gives no movement.
- Ball at y=1 moving up: next tick y=0 with direction down, following tick y=2.
- Ball at x=599 moving right with right_y=150 and ball_y=200: x=600, direction left. Same setup with right_y=0 and ball_y=300: advances to 601…619, then score_l increments, state returns to 1 and the ball recentres.
- score_l=8 and another right miss: score_l=9, state 3, outputs frozen across 10 ticks. A start pulse then gives state 1 with scores 0/0.
